serial_add_ctrl: RTL

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder with an IDLE/RUN/DONE controller. One sum bit is produced per RUN cycle, LSB first.
// Optional signed-overflow flag is enabled by defining SERIAL_ADD_OVF_EN; otherwise ovf is tied low.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic {NO_CARRY, CARRY} carry_t;

  state_t           state;
  carry_t           carry;
  carry_t           carry_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             a0;
  logic             b0;
  logic             s_bit;
  logic             last;

  always_comb begin
    a0        = a_sh[0];
    b0        = b_sh[0];
    s_bit     = a0 ^ b0 ^ (carry == CARRY);
    last      = (cnt == CW'(WIDTH - 1));
    carry_nxt = carry;
    // Carry is a two-state Mealy machine: set on generate (1,1), cleared on kill (0,0).
    case (carry)
      NO_CARRY: if (a0 && b0)   carry_nxt = CARRY;
      CARRY:    if (!a0 && !b0) carry_nxt = NO_CARRY;
      default:  carry_nxt = NO_CARRY;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      carry <= NO_CARRY;
      cnt   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a_in;
            b_sh  <= b_in;
            carry <= NO_CARRY;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          sum[cnt] <= s_bit;
          carry    <= carry_nxt;
          a_sh     <= a_sh >> 1;
          b_sh     <= b_sh >> 1;
          cnt      <= cnt + 1'b1;
          if (last) begin
            cout  <= (carry_nxt == CARRY);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  // On the final RUN cycle the shifters hold the operand MSBs, so no extra sign registers are needed.
  always_ff @(posedge i_clk) begin
    if (reset)
      ovf <= 1'b0;
    else if (state == IDLE && start)
      ovf <= 1'b0;
    else if (state == RUN && last)
      ovf <= (a0 == b0) && (s_bit != a0);
  end
`else
  assign ovf = 1'b0;
`endif

endmodule
